// File: rtl/dice_disp_pkg.sv
// Shared definitions for the dice display scanner.
// Holds the scan state encoding, the active-high 7-segment patterns
// ({dp,g,f,e,d,c,b,a}) and the digit code that means "show nothing".
package dice_disp_pkg;

    typedef enum logic [1:0] {
        BLANK_A = 2'd0,
        TENS    = 2'd1,
        BLANK_B = 2'd2,
        UNITS   = 2'd3
    } scan_state_t;

    localparam logic [7:0] SEG_0    = 8'h3F;
    localparam logic [7:0] SEG_1    = 8'h06;
    localparam logic [7:0] SEG_2    = 8'h5B;
    localparam logic [7:0] SEG_3    = 8'h4F;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'h6D;
    localparam logic [7:0] SEG_6    = 8'h7D;
    localparam logic [7:0] SEG_7    = 8'h07;
    localparam logic [7:0] SEG_8    = 8'h7F;
    localparam logic [7:0] SEG_9    = 8'h6F;
    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    localparam logic [3:0] DIGIT_BLANK = 4'd15;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to 7-segment decoder.
// Ports:
//   code    - 4-bit digit code: 0-9 numeric, 10-14 dash, 15 blank
//   pattern - active-high segment pattern {dp,g,f,e,d,c,b,a}; dp always 0
module seg7_decode
    import dice_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        case (code)
            4'd0:  pattern = SEG_0;
            4'd1:  pattern = SEG_1;
            4'd2:  pattern = SEG_2;
            4'd3:  pattern = SEG_3;
            4'd4:  pattern = SEG_4;
            4'd5:  pattern = SEG_5;
            4'd6:  pattern = SEG_6;
            4'd7:  pattern = SEG_7;
            4'd8:  pattern = SEG_8;
            4'd9:  pattern = SEG_9;
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14: pattern = SEG_DASH;
            default: pattern = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/dice_display_scan.sv
// Two-digit multiplexed 7-segment scan controller.
// Time-shares one segment bus between the tens and units commons with
// dead-time slots in between, latching the digit values once per frame.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   ena          - enable; low parks the scanner in BLANK_A with outputs off
//   digit1       - units digit code
//   digit10      - tens digit code
//   lz_blank     - blank the tens digit when it is 0
//   seg_pol      - segment lit level (1 = active high)
//   com_pol      - common active level (1 = active high)
//   seg_out      - segment bus {dp,g,f,e,d,c,b,a}, polarity applied
//   com1, com10  - units / tens commons
//   com_oe       - output enables for {com10,com1}
//   frame_start  - one-cycle pulse marking the shadow-digit load
module dice_display_scan
    import dice_disp_pkg::*;
#(
    parameter logic [7:0] SCAN_DIV     = 8'd250,
    parameter logic [3:0] BLANK_CYCLES = 4'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] digit1,
    input  logic [3:0] digit10,
    input  logic       lz_blank,
    input  logic       seg_pol,
    input  logic       com_pol,
    output logic [7:0] seg_out,
    output logic       com1,
    output logic       com10,
    output logic [1:0] com_oe,
    output logic       frame_start
);

    scan_state_t state;
    logic [7:0]  cnt;
    logic [3:0]  shadow1;
    logic [3:0]  shadow10;

    logic [7:0]  cnt_last;
    logic [3:0]  slot_code;
    logic [7:0]  slot_pattern;
    logic [7:0]  lit_pattern;
    logic [7:0]  unlit;
    logic        tens_blank;
    logic        load;

    // Slot lengths: digit slots use SCAN_DIV, dead-time slots BLANK_CYCLES.
    always_comb begin
        cnt_last = {4'd0, BLANK_CYCLES} - 8'd1;
        if (state == TENS || state == UNITS) begin
            cnt_last = SCAN_DIV - 8'd1;
        end
    end

    // Single decoder shared between the two digit slots.
    assign slot_code = (state == TENS) ? shadow10 : shadow1;

    seg7_decode u_decode (
        .code    (slot_code),
        .pattern (slot_pattern)
    );

    assign lit_pattern = seg_pol ? slot_pattern : ~slot_pattern;
    assign unlit       = {8{~seg_pol}};
    assign tens_blank  = lz_blank && (shadow10 == 4'd0);
    assign load        = (state == BLANK_A) && (cnt == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BLANK_A;
            cnt         <= '0;
            shadow1     <= DIGIT_BLANK;
            shadow10    <= DIGIT_BLANK;
            seg_out     <= '0;
            com1        <= 1'b0;
            com10       <= 1'b0;
            com_oe      <= '0;
            frame_start <= 1'b0;
        end else if (!ena) begin
            // Parking at BLANK_A/cnt 0 makes re-enable restart with a load.
            state       <= BLANK_A;
            cnt         <= '0;
            seg_out     <= unlit;
            com1        <= ~com_pol;
            com10       <= ~com_pol;
            com_oe      <= '0;
            frame_start <= 1'b0;
        end else begin
            com_oe      <= '1;
            frame_start <= load;
            if (load) begin
                shadow1  <= digit1;
                shadow10 <= digit10;
            end

            if (cnt == cnt_last) begin
                cnt <= '0;
                case (state)
                    BLANK_A: state <= TENS;
                    TENS:    state <= BLANK_B;
                    BLANK_B: state <= UNITS;
                    default: state <= BLANK_A;
                endcase
            end else begin
                cnt <= cnt + 8'd1;
            end

            // Outputs follow the current slot; only one common can be
            // driven active because each branch activates at most one.
            case (state)
                TENS: begin
                    com10   <= com_pol;
                    com1    <= ~com_pol;
                    seg_out <= tens_blank ? unlit : lit_pattern;
                end
                UNITS: begin
                    com10   <= ~com_pol;
                    com1    <= com_pol;
                    seg_out <= lit_pattern;
                end
                default: begin
                    com10   <= ~com_pol;
                    com1    <= ~com_pol;
                    seg_out <= unlit;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dice_display_scan.sv
// Directed bench for dice_display_scan with SCAN_DIV=8, BLANK_CYCLES=2
// (20-cycle frames: 2 blank, 8 tens, 2 blank, 8 units).
module tb_dice_display_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] digit1;
    logic [3:0] digit10;
    logic       lz_blank;
    logic       seg_pol;
    logic       com_pol;
    logic [7:0] seg_out;
    logic       com1;
    logic       com10;
    logic [1:0] com_oe;
    logic       frame_start;

    always #5 clk = ~clk;

    dice_display_scan #(
        .SCAN_DIV     (8'd8),
        .BLANK_CYCLES (4'd2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .digit1      (digit1),
        .digit10     (digit10),
        .lz_blank    (lz_blank),
        .seg_pol     (seg_pol),
        .com_pol     (com_pol),
        .seg_out     (seg_out),
        .com1        (com1),
        .com10       (com10),
        .com_oe      (com_oe),
        .frame_start (frame_start)
    );

    typedef struct {
        logic [3:0] d10;
        logic [3:0] d1;
        logic       lz;
        logic       sp;
        logic       cp;
        logic [7:0] exp_tens;
        logic [7:0] exp_units;
    } vec_t;

    vec_t vecs [8];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] obs();
        return {frame_start, com_oe, com10, com1, seg_out};
    endfunction

    // Expected {frame_start, com_oe, com10, com1, seg} at frame offset i.
    function automatic logic [12:0] expect_at(input int i, input logic sp, input logic cp,
                                              input logic [7:0] t, input logic [7:0] u);
        logic [7:0] unl;
        logic       fs;
        unl = sp ? 8'h00 : 8'hFF;
        fs  = (i == 0);
        if (i < 2 || (i >= 10 && i < 12)) return {fs, 2'b11, ~cp, ~cp, unl};
        else if (i < 10)                  return {fs, 2'b11, cp, ~cp, t};
        else                              return {fs, 2'b11, ~cp, cp, u};
    endfunction

    task automatic apply(input vec_t v);
        digit10  = v.d10;
        digit1   = v.d1;
        lz_blank = v.lz;
        seg_pol  = v.sp;
        com_pol  = v.cp;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 40);
        check(name, {15'd0, frame_start}, 16'd1);
    endtask

    // Called with the sample showing frame_start; checks all 20 cycles.
    task automatic check_frame(input vec_t v, input string tag);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) step();
            check($sformatf("%s_c%0d", tag, i), {3'd0, obs()},
                  {3'd0, expect_at(i, v.sp, v.cp, v.exp_tens, v.exp_units)});
        end
    endtask

    initial begin
        int  cp_used;
        logic both_active;

        vecs[0] = '{d10: 4'd4,  d1: 4'd2,  lz: 1'b0, sp: 1'b1, cp: 1'b1, exp_tens: 8'h66, exp_units: 8'h5B};
        vecs[1] = '{d10: 4'd0,  d1: 4'd8,  lz: 1'b1, sp: 1'b0, cp: 1'b0, exp_tens: 8'hFF, exp_units: 8'h80};
        vecs[2] = '{d10: 4'd15, d1: 4'd12, lz: 1'b0, sp: 1'b1, cp: 1'b1, exp_tens: 8'h00, exp_units: 8'h40};
        vecs[3] = '{d10: 4'd0,  d1: 4'd0,  lz: 1'b0, sp: 1'b1, cp: 1'b1, exp_tens: 8'h3F, exp_units: 8'h3F};
        vecs[4] = '{d10: 4'd9,  d1: 4'd5,  lz: 1'b1, sp: 1'b1, cp: 1'b0, exp_tens: 8'h6F, exp_units: 8'h6D};
        vecs[5] = '{d10: 4'd1,  d1: 4'd3,  lz: 1'b0, sp: 1'b0, cp: 1'b1, exp_tens: 8'hF9, exp_units: 8'hB0};
        vecs[6] = '{d10: 4'd10, d1: 4'd14, lz: 1'b1, sp: 1'b1, cp: 1'b1, exp_tens: 8'h40, exp_units: 8'h40};
        vecs[7] = '{d10: 4'd7,  d1: 4'd6,  lz: 1'b0, sp: 1'b1, cp: 1'b1, exp_tens: 8'h07, exp_units: 8'h7D};

        rst_n = 1'b0;
        ena   = 1'b1;
        apply(vecs[0]);
        #22;
        check("reset_values", {3'd0, obs()}, 16'd0);
        #5;
        rst_n = 1'b1;
        step();
        check("first_edge_load", {3'd0, obs()}, {3'd0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00});

        foreach (vecs[k]) begin
            apply(vecs[k]);
            wait_frame($sformatf("v%0d_frame", k));
            check_frame(vecs[k], $sformatf("v%0d", k));
        end

        // Mid-UNITS digit change must not tear the current frame.
        apply(vecs[0]);
        wait_frame("tear_frame");
        repeat (14) step();
        digit1 = 4'd7;
        for (int i = 15; i < 20; i++) begin
            step();
            check($sformatf("tear_hold_c%0d", i), {8'd0, seg_out}, 16'h005B);
        end
        wait_frame("tear_next_frame");
        repeat (12) step();
        check("tear_new_units", {7'd0, com1, seg_out}, {7'd0, 1'b1, 8'h07});

        // ena dropped for 5 cycles in the middle of TENS.
        wait_frame("ena_frame");
        repeat (5) step();
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("ena_low_c%0d", i), {3'd0, obs()}, 16'd0);
        end
        ena = 1'b1;
        step();
        check("ena_rise_load", {3'd0, obs()}, {3'd0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00});
        step();
        check("ena_blank_a2", {3'd0, obs()}, {3'd0, 1'b0, 2'b11, 1'b0, 1'b0, 8'h00});
        step();
        check("ena_tens", {3'd0, obs()}, {3'd0, 1'b0, 2'b11, 1'b1, 1'b0, 8'h66});

        // Asynchronous reset between edges during UNITS.
        wait_frame("rst_frame");
        repeat (14) step();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", {3'd0, obs()}, 16'd0);
        #2;
        rst_n = 1'b1;
        step();
        check("rst_release_load", {3'd0, obs()}, {3'd0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00});

        // Commons must never both be active under random polarity/ena changes.
        apply(vecs[2]);
        for (int i = 0; i < 1000; i++) begin
            seg_pol = 1'($urandom);
            com_pol = 1'($urandom);
            ena     = ($urandom_range(0, 7) != 0);
            cp_used = int'(com_pol);
            step();
            both_active = (com1 == 1'(cp_used)) && (com10 == 1'(cp_used));
            check($sformatf("no_overlap_%0d", i), {15'd0, both_active}, 16'd0);
        end

        ena = 1'b1;
        apply(vecs[2]);
        wait_frame("final_frame");
        check_frame(vecs[2], "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
